// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed seven-segment driver for NUM_DIGITS digits sharing one
//   active-low segment bus. A shadow register holds one 5-bit glyph code per
//   digit. A refresh counter steps through the digits. Each digit slot opens
//   with DEAD_CYCLES of all-anodes-off to suppress ghosting. Any digit can be
//   blanked on alternate blink half-periods.
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   codes_in    glyph codes, digit i at [i*CODE_W +: CODE_W]
//   load        capture codes_in into the shadow register on this edge
//   blink_en    per-digit blink enable, sampled live
//   seg_out     segments a..g (bit6=a, bit0=g), active-low, registered
//   an_out      digit anodes, active-low, bit i = digit i, registered
//   frame_tick  one-cycle pulse following the wrap from the last digit to digit 0
module seg_scan_driver #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned CODE_W      = 5,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned DEAD_CYCLES = 1000,
   parameter int unsigned BLINK_HALF  = 25000000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_DIGITS*CODE_W-1:0] codes_in,
   input  logic                         load,
   input  logic [NUM_DIGITS-1:0]        blink_en,
   output logic [6:0]                   seg_out,
   output logic [NUM_DIGITS-1:0]        an_out,
   output logic                         frame_tick
);

   localparam int unsigned SlotW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [SlotW-1:0]  SlotLast  = SlotW'(REFRESH_DIV - 1);
   localparam logic [SlotW-1:0]  DeadLimit = SlotW'(DEAD_CYCLES);
   localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_DIGITS - 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF - 1);

   localparam logic [6:0] SegBlank = 7'b1111111;

   // Glyph decode, active-low a..g. Codes above 16 all render as "0".
   function automatic logic [6:0] decode(input logic [CODE_W-1:0] code);
      logic [6:0] seg;
      case (code)
         5'd0:    seg = 7'b1111111;
         5'd1:    seg = 7'b1001111;
         5'd2:    seg = 7'b0010010;
         5'd3:    seg = 7'b0000110;
         5'd4:    seg = 7'b1001100;
         5'd5:    seg = 7'b0100100;
         5'd6:    seg = 7'b0100000;
         5'd7:    seg = 7'b0001111;
         5'd8:    seg = 7'b0000000;
         5'd9:    seg = 7'b0000100;
         5'd10:   seg = 7'b1111110;
         5'd11:   seg = 7'b1000001;
         5'd12:   seg = 7'b0001001;
         5'd13:   seg = 7'b0110001;
         5'd14:   seg = 7'b1110001;
         5'd15:   seg = 7'b1111110;
         5'd16:   seg = 7'b1000010;
         default: seg = 7'b0000001;
      endcase
      return seg;
   endfunction

   logic [SlotW-1:0]                   slot_q, slot_d;
   logic [IdxW-1:0]                    idx_q, idx_d;
   logic [BlinkW-1:0]                  blink_cnt_q, blink_cnt_d;
   logic                               blink_phase_q, blink_phase_d;
   logic [NUM_DIGITS-1:0][CODE_W-1:0]  shadow_q, shadow_d;
   logic [6:0]                         seg_q, seg_d;
   logic [NUM_DIGITS-1:0]              an_q, an_d;
   logic                               frame_tick_q, frame_tick_d;

   always_comb begin
      slot_d        = slot_q + SlotW'(1);
      idx_d         = idx_q;
      frame_tick_d  = 1'b0;
      blink_cnt_d   = blink_cnt_q + BlinkW'(1);
      blink_phase_d = blink_phase_q;
      shadow_d      = shadow_q;
      seg_d         = SegBlank;
      an_d          = '1;

      if (slot_q == SlotLast) begin
         slot_d = '0;
         if (idx_q == IdxLast) begin
            idx_d        = '0;
            frame_tick_d = 1'b1;
         end else begin
            idx_d = idx_q + IdxW'(1);
         end
      end

      if (blink_cnt_q == BlinkLast) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end

      // All digits replaced together; never a partial update.
      if (load) begin
         shadow_d = codes_in;
      end

      // Outputs come from pre-edge state only, so a new idx and a new shadow
      // captured on the same edge both appear together one edge later.
      if (slot_q >= DeadLimit) begin
         an_d = ~(NUM_DIGITS'(1) << idx_q);
         if (!(blink_en[idx_q] && !blink_phase_q)) begin
            seg_d = decode(shadow_q[idx_q]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_q        <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         shadow_q      <= '0;
         seg_q         <= SegBlank;
         an_q          <= '1;
         frame_tick_q  <= 1'b0;
      end else begin
         slot_q        <= slot_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         shadow_q      <= shadow_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         frame_tick_q  <= frame_tick_d;
      end
   end

   assign seg_out    = seg_q;
   assign an_out     = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver for N digits sharing one active-low segment bus.
- Holds a shadow register of 5-bit glyph codes and scans the digits with a refresh counter.
- Each digit slot starts with a dead-time interval to suppress ghosting, and any digit can be made to blink.
- Sits between the application/status logic and the board's segment and anode pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (≥2).
- CODE_W, 5: width of one glyph code (fixed decode table below; must be 5).
- REFRESH_DIV, 100000: clock cycles per digit slot (≥2).
- DEAD_CYCLES, 1000: cycles at the start of each slot with all anodes off (< REFRESH_DIV).
- BLINK_HALF, 25000000: clock cycles per blink half-period (≥1).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: synchronous active-low reset.
- codes_in, in, NUM_DIGITS*CODE_W: glyph codes. Digit i is bits [i*CODE_W +: CODE_W].
- load, in, 1: when high, capture codes_in into the shadow register on this edge.
- blink_en, in, NUM_DIGITS: per-digit blink enable, sampled live.
- seg_out, out, 7: segments, active-low. Bit6=a … bit0=g.
- an_out, out, NUM_DIGITS: digit anodes, active-low. Bit i selects digit i.
- frame_tick, out, 1: one-cycle pulse each time the scan wraps from digit NUM_DIGITS-1 to 0.

Behaviour:
- Reset (rst_n=0 at an edge) sets the following state:
  - shadow = all zeros (all digits blank)
  - slot counter = 0, digit index = 0
  - blink counter = 0, blink_phase = 1 (visible)
  - seg_out = 7'b1111111, an_out = all ones, frame_tick = 0
- Reset dominates load and all other activity.
- Slot counter: counts 0..REFRESH_DIV-1, then wraps to 0. On wrap, the digit index advances by 1 and wraps from NUM_DIGITS-1 to 0.
  - frame_tick is asserted on the cycle after the index wraps to 0.
- Blink counter: counts 0..BLINK_HALF-1 independently. blink_phase toggles on each wrap.
- Shadow register: when load=1, all NUM_DIGITS codes are replaced atomically. There are no partial updates.
- All outputs are registered. Each cycle, they are computed from the current state (idx, slot count, shadow, blink_phase, blink_en):
  - an_out = all ones if slot count < DEAD_CYCLES; otherwise ~(1<<idx).
  - seg_out = 7'b1111111 if slot count < DEAD_CYCLES, or if blink_en[idx]=1 and blink_phase=0; otherwise decode(shadow[idx]).
- Latency:
  - A load at edge k is visible on seg_out at edge k+1 if that digit is active.
  - An idx change at edge k is reflected on an_out/seg_out at edge k+1.
- Load on the same edge as a slot change: the new idx is paired with the new shadow, one edge later. No mixed glyph is ever driven.
- Decode table (active-low, a..g):

| Code | Glyph | Segments (a..g) |
|---|---|---|
| 0 | off | 1111111 |
| 1 | 1 | 1001111 |
| 2 | 2 | 0010010 |
| 3 | 3 | 0000110 |
| 4 | 4 | 1001100 |
| 5 | 5 | 0100100 |
| 6 | 6 | 0100000 |
| 7 | 7 | 0001111 |
| 8 | 8 | 0000000 |
| 9 | 9 | 0000100 |
| 10 | stable | 1111110 |
| 11 | up | 1000001 |
| 12 | down | 0001001 |
| 13 | C | 0110001 |
| 14 | L | 1110001 |
| 15 | tire | 1111110 |
| 16 | d | 1000010 |
| 17..31 | digit 0 | 0000001 |

- blink_en changes take effect on the next registered output. No resync of blink_phase occurs.

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, BLINK_HALF=64.
1. Reset, then idle, no load:
   - seg_out=7'h7F and an_out=4'hF during reset.
   - After release, an_out is 4'hF for 2 cycles, then 4'b1110 for 6 cycles, then 4'hF, 4'b1101, and so on.
   - seg_out stays 7'h7F throughout (all codes 0).
   - frame_tick pulses once every 32 cycles.
2. load=1 with codes {d3=13, d2=11, d1=2, d0=9}:
   - Over one frame, active slots show seg_out 0000100, 0010010, 1000001, 0110001, with the matching single anode low.
   - Dead-time cycles show 7'h7F / 4'hF.
3. Sweep codes 0..31 through digit 0 via successive loads:
   - seg_out during the digit-0 active window matches the decode table, including 0000001 for codes 17..31.
4. blink_en=4'b0100 with codes as in scenario 2:
   - Digit 2 shows 1000001 for 64 cycles, then 7'h7F (anode 4'b1011 still low) for 64 cycles, and repeats.
   - Other digits are unaffected.
5. Load pulse on the exact edge where the slot count wraps from 7 to 0:
   - The next active window shows only the new code, and no mixed glyph is driven.
   - The load is also repeated mid-slot: seg_out changes exactly one edge after the load edge.
6. Assert rst_n=0 mid-slot during digit 2:
   - At the next edge, all outputs return to reset values and the shadow is cleared.
   - After release, scanning restarts at digit 0 with dead time.
